tile_mem_arbiter: RTL
=====================

Name: tile_mem_arbiter

Overview:
Round-robin arbiter that shares one single-port synchronous SRAM (1-cycle read latency) between N_REQ requesters inside a tile, e.g. the core's ibus and dbus paths in front of the 2 KB data RAM. Each requester uses a valid/ready request channel and a valid/ready response channel. At most one access is in flight at a time. The response returns only to the requester that issued the access.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 9, SRAM word-address width (512 x 32-bit = 2 KB)
DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8 bits

Ports:
clk_core  in  1  core clock, all logic on rising edge
arst_core  in  1  asynchronous reset, active-low
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester request accept
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*ADDR_WIDTH  word address, requester i at slice i
req_wdata  in  N_REQ*DATA_WIDTH  write data, slice i
req_wstrb  in  N_REQ*DATA_WIDTH/8  byte strobes, slice i
rsp_valid  out  N_REQ  response valid, one-hot or zero
rsp_ready  in  N_REQ  response accept
rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters; qualified by rsp_valid
mem_en  out  1  SRAM enable
mem_we  out  DATA_WIDTH/8  SRAM byte write enables
mem_addr  out  ADDR_WIDTH  SRAM address
mem_wdata  out  DATA_WIDTH  SRAM write data
mem_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after mem_en

Behaviour:
- Reset (arst_core low, asynchronous): state IDLE, rr_ptr=0, owner=0, rsp_rdata register=0. req_ready, rsp_valid and mem_en are all 0. Reset during WAIT or RESP drops the in-flight access; no response is issued after reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
  - req_ready[g]=1, combinational. All other req_ready bits are 0.
  - If any request is valid: mem_en=1, mem_addr=req_addr[g], mem_wdata=req_wdata[g], mem_we = req_we[g] ? req_wstrb[g] : 0, all in the same cycle.
  - owner<=g, rr_ptr<=(g+1) mod N_REQ, then go to WAIT.
  - If no request is valid: mem_en=0, mem_we=0, rr_ptr unchanged.
- WAIT (exactly 1 cycle):
  - mem_en=0, all req_ready=0.
  - Register rsp_rdata<=mem_rdata for a read; rsp_rdata<=0 for a write.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_rdata holds its value.
  - If rsp_ready[owner]=1, go to IDLE next cycle. Otherwise stay in RESP indefinitely.
  - rsp_ready of non-owners is ignored. All req_ready=0.
- Latency: request handshake at cycle T; rsp_valid high from T+2. Peak throughput is one access per 3 cycles.
- mem_addr, mem_wdata and mem_we are don't-care when mem_en=0, except mem_we, which must be 0.
- Requesters must hold req_* stable while req_valid=1 and not accepted. The arbiter may switch the grant if a valid drops before acceptance; no state changes without a handshake.
- Writes always produce a response, with rsp_rdata=0.
- Outputs are never X after reset.

Test Plan:
- Single read: preload SRAM word 0x010=0xDEADBEEF; req 0 reads 0x010 at T -> req_ready[0]=1 and mem_en=1 at T; rsp_valid[0]=1 with rsp_rdata=0xDEADBEEF at T+2.
- Byte-strobe write: req 1 writes 0x11223344 to 0x005 with strobe 0b0101 over word 0xAAAAAAAA -> mem_we=0b0101 at T; write response has rsp_rdata=0; a following read of 0x005 returns 0xAA22AA44.
- Fairness: both requesters hold continuous valid reads after reset -> grants in order 0,1,0,1,0,1. Each access spans 3 cycles. rsp_valid is one-hot to the granted requester.
- Backpressure: rsp_ready[0]=0 for 5 cycles during RESP -> rsp_valid[0] stays 1 and rsp_rdata stays stable; req_ready stays 0 and mem_en stays 0 while req 1 waits. Releasing rsp_ready -> req 1 is granted in the next cycle.
- Reset mid-access: assert arst_core low while in WAIT -> rsp_valid=0 and mem_en=0 immediately. After release, rr_ptr=0, so with both requesters valid, req 0 wins first.
- Idle: no req_valid for 10 cycles -> mem_en=0, mem_we=0, rsp_valid=0 throughout, and rr_ptr unchanged.

Source files
------------

// File: rtl/tile_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between N_REQ
// requesters; one access in flight, response routed back to the issuing requester.
module tile_mem_arbiter #(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                            clk_core,
   input  logic                            arst_core,
   input  logic [N_REQ-1:0]                req_valid,
   output logic [N_REQ-1:0]                req_ready,
   input  logic [N_REQ-1:0]                req_we,
   input  logic [N_REQ*ADDR_WIDTH-1:0]     req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]     req_wdata,
   input  logic [N_REQ*(DATA_WIDTH/8)-1:0] req_wstrb,
   output logic [N_REQ-1:0]                rsp_valid,
   input  logic [N_REQ-1:0]                rsp_ready,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic                            mem_en,
   output logic [DATA_WIDTH/8-1:0]         mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   input  logic [DATA_WIDTH-1:0]           mem_rdata
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [PTR_W-1:0]        rr_ptr_r;
   logic [PTR_W-1:0]        owner_r;
   logic [PTR_W-1:0]        grant_s;
   logic [PTR_W-1:0]        rr_nxt_s;
   logic [PTR_W:0]          cand_s;
   logic                    any_valid_s;
   logic                    accept_s;
   logic                    is_write_r;
   logic [DATA_WIDTH-1:0]   rsp_rdata_r;
   logic [ADDR_WIDTH-1:0]   gnt_addr_s;
   logic [DATA_WIDTH-1:0]   gnt_wdata_s;
   logic [STRB_W-1:0]       gnt_wstrb_s;
   logic                    gnt_we_s;
   logic                    gnt_sel_s;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      any_valid_s = 1'b0;
      grant_s     = '0;
      cand_s      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_s      = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
         cand_s      = (cand_s >= (PTR_W+1)'(N_REQ)) ? cand_s - (PTR_W+1)'(N_REQ) : cand_s;
         grant_s     = (!any_valid_s && req_valid[cand_s[PTR_W-1:0]]) ? cand_s[PTR_W-1:0] : grant_s;
         any_valid_s = any_valid_s | req_valid[cand_s[PTR_W-1:0]];
      end
      rr_nxt_s = (grant_s == PTR_W'(N_REQ-1)) ? '0 : grant_s + PTR_W'(1);
   end

   // Steer the granted requester's address, data and strobes onto the SRAM side.
   always_comb begin
      gnt_addr_s  = '0;
      gnt_wdata_s = '0;
      gnt_wstrb_s = '0;
      gnt_we_s    = 1'b0;
      gnt_sel_s   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         gnt_sel_s   = (grant_s == PTR_W'(i));
         gnt_addr_s  = gnt_sel_s ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  : gnt_addr_s;
         gnt_wdata_s = gnt_sel_s ? req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : gnt_wdata_s;
         gnt_wstrb_s = gnt_sel_s ? req_wstrb[i*STRB_W +: STRB_W]        : gnt_wstrb_s;
         gnt_we_s    = gnt_sel_s ? req_we[i]                            : gnt_we_s;
      end
   end

   // FSM next state and handshake/SRAM outputs; reset forces every strobe low at once.
   always_comb begin
      state_nxt_s = state_r;
      req_ready   = '0;
      rsp_valid   = '0;
      mem_en      = 1'b0;
      mem_we      = '0;
      mem_addr    = gnt_addr_s;
      mem_wdata   = gnt_wdata_s;
      accept_s    = 1'b0;
      if (!arst_core) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_valid_s) begin
                  req_ready   = ONE_HOT0 << grant_s;
                  mem_en      = 1'b1;
                  mem_we      = gnt_we_s ? gnt_wstrb_s : '0;
                  accept_s    = 1'b1;
                  state_nxt_s = ST_WAIT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_WAIT: begin
               state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
               rsp_valid = ONE_HOT0 << owner_r;
               if (rsp_ready[owner_r]) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_RESP;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, arbitration pointer, owner and captured response data.
   always_ff @(posedge clk_core or negedge arst_core) begin
      if (!arst_core) begin
         state_r     <= ST_IDLE;
         rr_ptr_r    <= '0;
         owner_r     <= '0;
         is_write_r  <= 1'b0;
         rsp_rdata_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            owner_r    <= grant_s;
            rr_ptr_r   <= rr_nxt_s;
            is_write_r <= gnt_we_s;
         end
         // SRAM data is valid the cycle after the enable; writes answer with zero.
         if (state_r == ST_WAIT) begin
            rsp_rdata_r <= is_write_r ? '0 : mem_rdata;
         end
      end
   end

   assign rsp_rdata = rsp_rdata_r;

endmodule
